// File: rtl/seven_segment_pkg.sv
// Shared types, segment constants and the digit-to-pattern decoder for the scan display.
// Pure definitions; no timing or flow control of its own.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_ERROR = 7'b1001111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } bcd_state_e;

  // Segment order is a..g from bit 6 down to bit 0, active-high.
  function automatic seg_t seg_decode(input logic [3:0] i_code);
    seg_t r_pat;
    case (i_code)
      4'd0:    r_pat = 7'b1111110;
      4'd1:    r_pat = 7'b0110000;
      4'd2:    r_pat = 7'b1101101;
      4'd3:    r_pat = 7'b1111001;
      4'd4:    r_pat = 7'b0110011;
      4'd5:    r_pat = 7'b1011011;
      4'd6:    r_pat = 7'b1011111;
      4'd7:    r_pat = 7'b1110000;
      4'd8:    r_pat = 7'b1111111;
      4'd9:    r_pat = 7'b1111011;
      default: r_pat = SEG_ERROR;
    endcase
    return r_pat;
  endfunction

endpackage

// File: rtl/binary_to_bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per cycle, DATA_W cycles per value.
// Start is accepted only while idle; requests during a conversion are dropped, not queued.
module binary_to_bcd_serial
  import seven_segment_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  bcd_state_e        r_state;
  bcd_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_step;
  logic [SR_W-1:0]   r_shift;
  logic [BCD_W-1:0]  w_adj;
  logic [SR_W-1:0]   w_shifted;
  logic              w_last;
  logic              w_accept;

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_adj[4*i +: 4] = (r_shift[DATA_W+4*i +: 4] >= 4'd5) ? r_shift[DATA_W+4*i +: 4] + 4'd3
                                                           : r_shift[DATA_W+4*i +: 4];
    end
  end

  assign w_shifted = {w_adj, r_shift[DATA_W-1:0]} << 1;
  assign w_last    = (r_step == LAST_STEP);

  // Exposes the post-step BCD field so the caller can commit it on the final edge.
  assign o_bcd = w_shifted[SR_W-1 -: BCD_W];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        o_busy = 1'b1;
        if (w_last) begin
          o_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_step  <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_step  <= '0;
      r_shift <= {{BCD_W{1'b0}}, i_value};
    end else if (o_busy) begin
      r_step  <= r_step + CNT_W'(1);
      r_shift <= w_shifted;
    end
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Converts a loaded binary value to BCD and time-multiplexes it onto common-anode digits.
// Pins update one cycle after the display register; loads arriving while busy are ignored.
module seven_segment_scan_controller
  import seven_segment_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [DATA_W-1:0]   i_value,
  input  logic                i_blank_zeros,
  output logic                o_busy,
  output logic [DIGITS-1:0]   o_anode,
  output logic [6:0]          o_segments
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if ((longint'(10) ** DIGITS) <= (longint'(1) << DATA_W)) begin : g_bad_digits
      $error("DIGITS too small to hold every DATA_W-bit value");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
      $error("REFRESH_DIV must be at least 2");
    end
  endgenerate

  logic [4*DIGITS-1:0] r_display;
  logic [CNT_W-1:0]    r_refresh;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_anode;
  seg_t                r_segments;

  logic [4*DIGITS-1:0] w_bcd;
  logic                w_done;
  logic [DIGITS-1:0]   w_lead_zero;
  logic                w_run_zero;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic [DIGITS-1:0]   w_anode;
  seg_t                w_seg;

  binary_to_bcd_serial #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_load),
    .i_value (i_value),
    .o_busy  (o_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // w_lead_zero[i]: nibbles i..DIGITS-1 of the display are all zero.
  always_comb begin
    w_lead_zero = '0;
    w_run_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run_zero     = w_run_zero && (r_display[4*i +: 4] == 4'd0);
      w_lead_zero[i] = w_run_zero;
    end
  end

  always_comb begin
    w_digit = '0;
    w_blank = 1'b0;
    w_anode = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit    = r_display[4*i +: 4];
        w_blank    = (i != 0) && i_blank_zeros && w_lead_zero[i];
        w_anode[i] = 1'b0;
      end
    end
    w_seg = w_blank ? SEG_BLANK : seg_decode(w_digit);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_display  <= '0;
      r_refresh  <= '0;
      r_idx      <= '0;
      r_anode    <= '1;
      r_segments <= SEG_BLANK;
    end else begin
      if (w_done) begin
        r_display <= w_bcd;
      end
      if (r_refresh == CNT_W'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_idx     <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_refresh <= r_refresh + CNT_W'(1);
      end
      r_anode    <= w_anode;
      r_segments <= w_seg;
    end
  end

  assign o_anode    = r_anode;
  assign o_segments = r_segments;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the scan controller: reset, scan order, conversions, blanking, load drop and mid-conversion reset.
// Expected segment patterns are hand-coded constants.
module tb_seven_segment_scan_controller;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PB = 7'b0000000;
  localparam logic [6:0] PE = 7'b1001111;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] value;
  logic       blank_zeros;
  logic       busy;
  logic [2:0] anode;
  logic [6:0] segments;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_scan_controller #(
    .DATA_W      (8),
    .DIGITS      (3),
    .REFRESH_DIV (4)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_load        (load),
    .i_value       (value),
    .i_blank_zeros (blank_zeros),
    .o_busy        (busy),
    .o_anode       (anode),
    .o_segments    (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses load and counts sampled cycles with busy high; optionally drives
  // a second load so that it is sampled on edge N+extra_edge.
  task automatic run_load(input logic [7:0] v, input int extra_edge,
                          input logic [7:0] extra_v, output int busy_cycles);
    int k;
    busy_cycles = 0;
    load  = 1'b1;
    value = v;
    tick();
    load = 1'b0;
    k = 0;
    while (k < 40) begin
      if (busy) busy_cycles++;
      else break;
      if (k + 1 == extra_edge) begin
        load  = 1'b1;
        value = extra_v;
      end else begin
        load = 1'b0;
      end
      tick();
      k++;
    end
    load = 1'b0;
  endtask

  // One full scan period plus one: captures the pattern shown for each digit.
  task automatic read_digits(output logic [6:0] d0, output logic [6:0] d1,
                             output logic [6:0] d2, output logic bad);
    d0 = 'x;
    d1 = 'x;
    d2 = 'x;
    bad = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (segments == PE) bad = 1'b1;
      case (anode)
        3'b110:  d0 = segments;
        3'b101:  d1 = segments;
        3'b011:  d2 = segments;
        default: bad = 1'b1;
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] d0, d1, d2;
    logic       bad;
    int         bc;

    reset       = 1'b1;
    load        = 1'b0;
    value       = '0;
    blank_zeros = 1'b0;

    #12;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_anode", anode, 3'b111);
    check_eq("rst_seg", segments, PB);
    @(negedge clk);
    reset = 1'b0;

    tick();
    check_eq("first_anode", anode, 3'b110);
    check_eq("first_seg", segments, P0);
    repeat (3) tick();
    check_eq("scan_e4", anode, 3'b110);
    tick();
    check_eq("scan_e5", anode, 3'b101);
    repeat (4) tick();
    check_eq("scan_e9", anode, 3'b011);
    repeat (4) tick();
    check_eq("scan_e13", anode, 3'b110);

    // 255 -> "255"
    run_load(8'd255, 0, 8'd0, bc);
    check_eq("busy_255", bc, 8);
    read_digits(d0, d1, d2, bad);
    check_eq("v255_d0", d0, P5);
    check_eq("v255_d1", d1, P5);
    check_eq("v255_d2", d2, P2);
    check_eq("v255_scan", bad, 1'b0);

    // 7 with leading-zero blanking, then blanking released
    blank_zeros = 1'b1;
    run_load(8'd7, 0, 8'd0, bc);
    check_eq("busy_7", bc, 8);
    read_digits(d0, d1, d2, bad);
    check_eq("v7b_d0", d0, P7);
    check_eq("v7b_d1", d1, PB);
    check_eq("v7b_d2", d2, PB);
    blank_zeros = 1'b0;
    tick();
    check_eq("unblank_1cyc", segments, (anode == 3'b110) ? P7 : P0);
    read_digits(d0, d1, d2, bad);
    check_eq("v7_d0", d0, P7);
    check_eq("v7_d1", d1, P0);
    check_eq("v7_d2", d2, P0);

    // 100 with a load of 42 pulsed mid-conversion
    run_load(8'd100, 3, 8'd42, bc);
    check_eq("busy_100", bc, 8);
    tick();
    tick();
    check_eq("no_queue_busy", busy, 1'b0);
    read_digits(d0, d1, d2, bad);
    check_eq("v100_d0", d0, P0);
    check_eq("v100_d1", d1, P0);
    check_eq("v100_d2", d2, P1);

    // load coinciding with the falling edge of busy is dropped
    blank_zeros = 1'b1;
    run_load(8'd9, 8, 8'd55, bc);
    check_eq("busy_9", bc, 8);
    tick();
    check_eq("edge_load_busy", busy, 1'b0);
    read_digits(d0, d1, d2, bad);
    check_eq("v9_d0", d0, P9);
    check_eq("v9_d1", d1, PB);
    check_eq("v9_d2", d2, PB);
    check_eq("v9_scan", bad, 1'b0);

    // reset during a conversion of 199
    load  = 1'b1;
    value = 8'd199;
    tick();
    load = 1'b0;
    check_eq("v199_busy", busy, 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_anode", anode, 3'b111);
    check_eq("midrst_seg", segments, PB);
    @(negedge clk);
    reset = 1'b0;
    read_digits(d0, d1, d2, bad);
    check_eq("postrst_d0", d0, P0);
    check_eq("postrst_d1", d1, PB);
    check_eq("postrst_d2", d2, PB);
    check_eq("postrst_busy", busy, 1'b0);

    // back-to-back loads, each issued the cycle after busy falls
    run_load(8'd9, 0, 8'd0, bc);
    check_eq("b2b_busy_9", bc, 8);
    run_load(8'd10, 0, 8'd0, bc);
    check_eq("b2b_busy_10", bc, 8);
    read_digits(d0, d1, d2, bad);
    check_eq("v10_d0", d0, P0);
    check_eq("v10_d1", d1, P1);
    check_eq("v10_d2", d2, PB);
    check_eq("v10_scan", bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
